// File: rtl/pwm_pkg.sv
// Shared constants for the PWM duty meter: FSM state encoding and us-counter saturation.
package pwm_pkg;

    localparam logic [1:0] ST_WAIT_RISE = 2'd0;
    localparam logic [1:0] ST_MEAS_HIGH = 2'd1;
    localparam logic [1:0] ST_MEAS_LOW  = 2'd2;

    localparam logic [10:0] US_SAT = 11'd2047;

    // Increment that sticks at US_SAT instead of wrapping.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == US_SAT) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Measurement bus of the PWM duty meter: the PWM input and the result/static outputs.
interface pwm_duty_meter_if;

    logic        pwm_in;
    logic [10:0] period_us;
    logic [10:0] high_us;
    logic        meas_vld;
    logic        static_lvl;
    logic        static_flg;

    modport master (
        output pwm_in,
        input  period_us, high_us, meas_vld, static_lvl, static_flg
    );

    modport slave (
        input  pwm_in,
        output period_us, high_us, meas_vld, static_lvl, static_flg
    );

endinterface

// File: rtl/pwm_edge_det.sv
// Synchroniser, optional glitch filter and edge detector for the PWM input.
// Define PWM_GLITCH_FILTER_EN to require FILT_LEN stable samples before pwm_s changes.
module pwm_edge_det #(
    parameter logic [2:0] FILT_LEN = 3'd4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise,
    output logic fall
);

    if (FILT_LEN == 3'd0) begin : g_filt_len_chk
        $error("pwm_edge_det: FILT_LEN must be at least 1");
    end

    logic [1:0] sync_q;
    logic       pwm_d;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], pwm_in};
    end

`ifdef PWM_GLITCH_FILTER_EN
    logic [2:0] filt_cnt;
    logic       filt_q;

    // Count consecutive samples that disagree with the filtered level; any agreement restarts.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            filt_cnt <= 3'd0;
            filt_q   <= 1'b0;
        end else if (sync_q[1] == filt_q) begin
            filt_cnt <= 3'd0;
        end else if (filt_cnt == FILT_LEN - 3'd1) begin
            filt_q   <= sync_q[1];
            filt_cnt <= 3'd0;
        end else begin
            filt_cnt <= filt_cnt + 3'd1;
        end
    end

    assign pwm_s = filt_q;
`else
    assign pwm_s = sync_q[1];
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) pwm_d <= 1'b0;
        else         pwm_d <= pwm_s;
    end

    assign rise =  pwm_s & ~pwm_d;
    assign fall = ~pwm_s &  pwm_d;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM period / high-time meter in microseconds with static-level detection.
// Optional glitch filtering is enabled in pwm_edge_det by defining PWM_GLITCH_FILTER_EN.
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter logic [5:0]  CNT_1US_MAX = 6'd49,
    parameter logic [10:0] TIMEOUT_US  = 11'd2000,
    parameter logic [2:0]  FILT_LEN    = 3'd4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pwm_in,
    output logic [10:0] period_us,
    output logic [10:0] high_us,
    output logic        meas_vld,
    output logic        static_lvl,
    output logic        static_flg
);

    logic        pwm_s;
    logic        rise;
    logic        fall;
    logic [5:0]  presc;
    logic        tick_us;
    logic [10:0] us_cnt;
    logic [10:0] high_q;
    logic [1:0]  state;
    logic        timeout;

    pwm_edge_det #(.FILT_LEN(FILT_LEN)) u_edge_det (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .pwm_in  (pwm_in),
        .pwm_s   (pwm_s),
        .rise    (rise),
        .fall    (fall)
    );

    assign tick_us = (presc == CNT_1US_MAX);

    // Fires only on the tick that carries the counter onto TIMEOUT_US, so it pulses once per idle spell.
    assign timeout = tick_us && !rise && (us_cnt == TIMEOUT_US - 11'd1);

    // Prescaler restarts on every rising edge so us ticks are phase-aligned to the period start.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || rise || tick_us) presc <= 6'd0;
        else                            presc <= presc + 6'd1;
    end

    // A rising edge wins over a coincident tick: the counter clears and that tick is dropped.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || rise) us_cnt <= 11'd0;
        else if (tick_us)    us_cnt <= sat_inc(us_cnt);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_WAIT_RISE;
            high_q     <= 11'd0;
            period_us  <= 11'd0;
            high_us    <= 11'd0;
            meas_vld   <= 1'b0;
            static_lvl <= 1'b0;
            static_flg <= 1'b0;
        end else begin
            meas_vld <= 1'b0;
            if (rise) static_flg <= 1'b0;

            if (timeout) begin
                static_flg <= 1'b1;
                static_lvl <= pwm_s;
                period_us  <= 11'd0;
                high_us    <= pwm_s ? US_SAT : 11'd0;
                meas_vld   <= 1'b1;
                state      <= ST_WAIT_RISE;
            end else begin
                case (state)
                    ST_WAIT_RISE: if (rise) state <= ST_MEAS_HIGH;
                    ST_MEAS_HIGH: if (fall) begin
                        high_q <= us_cnt;
                        state  <= ST_MEAS_LOW;
                    end
                    ST_MEAS_LOW: if (rise) begin
                        period_us <= us_cnt;
                        high_us   <= high_q;
                        meas_vld  <= 1'b1;
                        state     <= ST_MEAS_HIGH;
                    end
                    default: state <= ST_WAIT_RISE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: a segment-level model predicts every meas_vld
// pulse (values and cycle) and a monitor compares whenever the DUT pulses.
module tb_pwm_duty_meter;
    import pwm_pkg::*;

    localparam int P      = 2;     // sys_clk cycles per us (CNT_1US_MAX = 1)
    localparam int TO_US  = 2000;
    localparam int F      = 4;
`ifdef PWM_GLITCH_FILTER_EN
    localparam int LAT    = 3 + F; // pwm_in change -> edge seen by the FSM
`else
    localparam int LAT    = 3;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   cyc     = 0;

    pwm_duty_meter_if bus();

    pwm_duty_meter #(.CNT_1US_MAX(6'd1)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pwm_in     (bus.pwm_in),
        .period_us  (bus.period_us),
        .high_us    (bus.high_us),
        .meas_vld   (bus.meas_vld),
        .static_lvl (bus.static_lvl),
        .static_flg (bus.static_flg)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int period;
        int high;
        bit flg;
        bit lvl;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: each segment boundary becomes an edge seen LAT cycles later;
    // the us counter at cycle t is the number of whole us elapsed since the origin, minus the edge cycle.
    int m_phase = 0;   // 0 waiting for rise, 1 in high, 2 in low
    int m_org   = 0;
    int m_high  = 0;
    bit m_level = 0;
    bit m_to_done = 0;

    function automatic int us_at(input int t);
        int v;
        v = (t > m_org) ? (t - m_org - 1) / P : 0;
        return (v > int'(US_SAT)) ? int'(US_SAT) : v;
    endfunction

    task automatic model_advance(input int t);
        int t_to;
        t_to = m_org + TO_US * P;
        if (!m_to_done && t_to < t) begin
            exp_q.push_back('{period: 0, high: m_level ? int'(US_SAT) : 0,
                              flg: 1'b1, lvl: m_level, at: t_to});
            m_phase   = 0;
            m_to_done = 1'b1;
        end
    endtask

    task automatic model_edge(input int t, input bit lvl);
        model_advance(t);
        if (lvl) begin
            if (m_phase == 2)
                exp_q.push_back('{period: us_at(t), high: m_high, flg: 1'b0, lvl: 1'b0, at: t});
            m_phase   = 1;
            m_org     = t;
            m_to_done = 1'b0;
        end else if (m_phase == 1) begin
            m_high  = us_at(t);
            m_phase = 2;
        end
        m_level = lvl;
    endtask

    // Drive pwm_in to lvl for n cycles (called on a falling clock edge).
    task automatic seg(input bit lvl, input int n);
        int det;
        det = cyc + LAT;
        if (lvl != bus.pwm_in) begin
            bus.pwm_in = lvl;
            model_edge(det, lvl);
        end
        model_advance(det + n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Invert pwm_in for n cycles, then restore it.
    task automatic glitch(input int n);
        bit cur;
        cur = bus.pwm_in;
`ifdef PWM_GLITCH_FILTER_EN
        bus.pwm_in = ~cur;
        repeat (n) @(negedge sys_clk);
        bus.pwm_in = cur;
`else
        seg(~cur, n);
        seg(cur, 0);
`endif
    endtask

    task automatic do_reset();
        bus.pwm_in = 1'b0;
        sys_rst    = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst    = 1'b0;
        exp_q.delete();
        m_phase   = 0;
        m_org     = cyc;
        m_high    = 0;
        m_level   = 1'b0;
        m_to_done = 1'b0;
        check("rst_period_us",  int'(bus.period_us),  0);
        check("rst_high_us",    int'(bus.high_us),    0);
        check("rst_meas_vld",   int'(bus.meas_vld),   0);
        check("rst_static_lvl", int'(bus.static_lvl), 0);
        check("rst_static_flg", int'(bus.static_flg), 0);
    endtask

    // Monitor: every meas_vld cycle must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst && bus.meas_vld) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_meas_vld: period_us=%0d high_us=%0d at cycle %0d, expected no pulse",
                         bus.period_us, bus.high_us, cyc);
            end else begin
                e = exp_q.pop_front();
                check("period_us",  int'(bus.period_us),  e.period);
                check("high_us",    int'(bus.high_us),    e.high);
                check("static_flg", int'(bus.static_flg), int'(e.flg));
                if (e.flg) check("static_lvl", int'(bus.static_lvl), int'(e.lvl));
                check("meas_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        repeat (95000) @(posedge sys_clk);
        $display("FAIL watchdog: cycle budget of %0d exhausted, expected run to finish", 95000);
        $fatal(1);
    end

    initial begin
        bus.pwm_in = 1'b0;
        @(negedge sys_clk);
        do_reset();

        // 0 % duty then 100 % duty held for 3 ms
        seg(1'b0, 4200);
        seg(1'b1, 6000);

        // 1 kHz, 300 us high; edges land on tick cycles
        repeat (3) begin
            seg(1'b0, 1400);
            seg(1'b1, 600);
        end
        seg(1'b0, 1401);
        seg(1'b1, 601);

        for (int i = 0; i < 12; i++) begin
            seg(1'b0, int'($urandom_range(1500, 8)));
            seg(1'b1, int'($urandom_range(1500, 8)));
        end

        // Short low glitch inside a high phase
        seg(1'b0, 1400);
        seg(1'b1, 200);
        glitch(2);
        seg(1'b1, 398);
        seg(1'b0, 1400);
        seg(1'b1, 600);

        // Reset 500 us into a period, then two rising edges before the next result
        seg(1'b0, 1400);
        seg(1'b1, 600);
        seg(1'b0, 400);
        check("pending_before_reset", exp_q.size(), 0);
        do_reset();
        seg(1'b0, 300);
        seg(1'b1, 600);
        seg(1'b0, 1400);
        seg(1'b1, 500);
        seg(1'b0, 1500);
        seg(1'b1, 500);

        // Stuck low after a period: static low from MEAS_LOW
        seg(1'b0, 4200);
        repeat (4) @(negedge sys_clk);
        check("pending_expectations", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 SHALL have parameter CNT_1US_MAX, default 6'd49: sys_clk cycles per 1 us tick, minus 1.
REQ-002 SHALL have parameter TIMEOUT_US, default 11'd2000: edge-free time in us that declares the input static.
REQ-003 SHALL have parameter FILT_LEN, default 3'd4: number of stable samples the glitch filter requires.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port pwm_in, input, 1 bit: the PWM to measure, asynchronous to sys_clk.
REQ-007 SHALL have port period_us, output, 11 bits: last full period in us.
REQ-008 SHALL have port high_us, output, 11 bits: high time within that period in us.
REQ-009 SHALL have port meas_vld, output, 1 bit: one-cycle pulse when period_us and high_us update.
REQ-010 SHALL have port static_lvl, output, 1 bit: input level while static_flg is 1.
REQ-011 SHALL have port static_flg, output, 1 bit: no edge seen for TIMEOUT_US.

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchroniser; all later logic uses the synchronised value pwm_s.
REQ-013 SHALL run a 6-bit prescaler 0..CNT_1US_MAX and assert tick_us for one cycle at CNT_1US_MAX.
REQ-014 SHALL restart the prescaler at 0 on every detected rising edge, so that measurement is phase-aligned to the edge.
REQ-015 SHALL use an FSM with states WAIT_RISE, MEAS_HIGH and MEAS_LOW; WAIT_RISE is the reset state.
REQ-016 SHALL, in WAIT_RISE, clear the us counter on a rising edge and go to MEAS_HIGH; no output is produced.
REQ-017 SHALL, in MEAS_HIGH, latch the us counter into an internal high register on a falling edge and go to MEAS_LOW.
REQ-018 SHALL, in MEAS_LOW on a rising edge, load period_us with the us counter and high_us with the high register, pulse meas_vld, clear the us counter and go to MEAS_HIGH.
REQ-019 SHALL make meas_vld rise one cycle after the cycle in which the rising edge of pwm_s is detected.
REQ-020 SHALL increment the 11-bit us counter on tick_us and saturate it at 2047, never wrapping.
REQ-021 SHALL give an edge priority over tick_us in the same cycle: the counter clears and the tick is not counted.
REQ-022 SHALL, when the us counter reaches TIMEOUT_US in any state: set static_flg=1, set static_lvl=pwm_s, load period_us=0, load high_us=2047 if pwm_s=1 else 0, pulse meas_vld once, and go to WAIT_RISE.
REQ-023 SHALL clear static_flg on the next detected rising edge.
REQ-024 SHALL leave period_us and high_us holding their last values between meas_vld pulses.

Reset
REQ-025 SHALL, while sys_rst=1 at a clock edge, set period_us=0, high_us=0, meas_vld=0, static_lvl=0, static_flg=0, all counters and synchroniser flops to 0, and the FSM to WAIT_RISE.
REQ-026 SHALL, on reset mid-measurement, discard the partial measurement and emit no meas_vld until one full period has been seen after reset.

Configuration
REQ-027 SHALL, when macro PWM_GLITCH_FILTER_EN is defined, change pwm_s only after the synchronised input has held a new level for FILT_LEN consecutive sys_clk cycles, which adds FILT_LEN cycles of latency to every edge.
REQ-028 SHALL, when PWM_GLITCH_FILTER_EN is undefined, use the synchroniser output directly and include no filter logic.

Structure
REQ-029 SHALL define the FSM state encoding and the saturation constant 11'd2047 in shared package pwm_pkg.
REQ-030 SHALL put the synchroniser, the optional filter and edge detection in sub-module pwm_edge_det (outputs pwm_s, rise, fall).

Verification
REQ-031 SHALL cover: 1 kHz PWM with 300 us high, CNT_1US_MAX=49 -> after the second rising edge, meas_vld with period_us=1000 and high_us=300 (+/-1).
REQ-032 SHALL cover: pwm_in held 1 for 3 ms -> at 2000 us, static_flg=1, static_lvl=1, period_us=0, high_us=2047, one meas_vld.
REQ-033 SHALL cover: 0 % then 100 % duty, i.e. constant low then constant high -> static_flg with static_lvl=0 then static_lvl=1, high_us=0 then 2047.
REQ-034 SHALL cover: sys_rst asserted at 500 us into a period -> all outputs 0, and the first meas_vld only after two further rising edges.
REQ-035 SHALL cover: with PWM_GLITCH_FILTER_EN, a 2-cycle low glitch during the high phase -> no state change and high_us unaffected; without the macro, the glitch ends the high phase early and a short high_us is reported.
REQ-036 SHALL cover: a rising edge coincident with tick_us -> us counter cleared and the next period_us counted exactly.
